// File: rtl/outlier_pkg.sv
// Shared widths and the pipeline stage record for the time-multiplexed outlier engine.
// The record widths follow the package defaults (N_CH_P channels, DW_P-bit samples).
package outlier_pkg;

  localparam int unsigned N_CH_P = 4;
  localparam int unsigned DW_P   = 10;
  localparam int unsigned CW     = (N_CH_P > 1) ? $clog2(N_CH_P) : 1;
  localparam int unsigned MW     = DW_P + 2;   // signed mean / deviation width
  localparam int unsigned D2W    = 2 * MW;     // squared deviation / variance width
  localparam int unsigned TW     = D2W + 4;    // threshold width (var * K2)
  localparam int unsigned CNTW   = 8;          // warm-up counter width, WARMUP <= 255

  // One in-flight sample: channel, deviation and the channel state read at accept.
  typedef struct packed {
    logic                 v;
    logic [CW-1:0]        ch;
    logic signed [MW-1:0] d;
    logic signed [MW-1:0] mean;
    logic [D2W-1:0]       vr;
    logic [CNTW-1:0]      cnt;
  } stage_t;

endpackage

// File: rtl/outlier_irq_gen.sv
// Sticky per-channel status register and rate-limited interrupt pulse.
// Ports: evt_c      - outlier result that becomes visible on o_valid next cycle
//        res_*      - registered result (o_valid/o_ch/o_outlier) used to set status
//        status_clr - write-1-to-clear, loses to a simultaneous set
//        status/irq - registered outputs
module outlier_irq_gen
  import outlier_pkg::*;
#(
  parameter int unsigned N_CH    = N_CH_P,
  parameter int unsigned HOLDOFF = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            evt_c,
  input  logic            res_valid,
  input  logic [CW-1:0]   res_ch,
  input  logic            res_outlier,
  input  logic [N_CH-1:0] status_clr,
  output logic [N_CH-1:0] status,
  output logic            irq
);

  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [HW-1:0]   hold_q, hold_d;
  logic            irq_q, irq_d;
  logic [N_CH-1:0] status_q, status_d;
  logic [N_CH-1:0] set_c;

  // irq fires only from a quiet holdoff; every outlier re-arms the quiet window.
  always_comb begin
    irq_d  = evt_c && (hold_q == '0);
    hold_d = hold_q;
    if (evt_c) begin
      hold_d = HW'(HOLDOFF);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
    set_c = '0;
    if (res_valid && res_outlier) begin
      set_c[res_ch] = 1'b1;
    end
    status_d = (status_q & ~status_clr) | set_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      irq_q    <= 1'b0;
      status_q <= '0;
    end else begin
      hold_q   <= hold_d;
      irq_q    <= irq_d;
      status_q <= status_d;
    end
  end

  assign status = status_q;
  assign irq    = irq_q;

endmodule

// File: rtl/outlier_engine_tdm.sv
// Time-multiplexed EMA outlier detector: one 3-stage datapath shared by N_CH channels.
// Ports: s_valid/s_ready/s_ch/s_data - tagged sample input (s_ready is combinational on s_ch)
//        o_valid/o_ch/o_outlier/o_dev2 - registered result, three cycles after accept
//        status/status_clr/irq         - sticky flags and rate-limited interrupt
module outlier_engine_tdm
  import outlier_pkg::*;
#(
  parameter int unsigned N_CH    = N_CH_P,
  parameter int unsigned DW      = DW_P,
  parameter int unsigned MSHIFT  = 4,
  parameter int unsigned VSHIFT  = 4,
  parameter int unsigned K2      = 9,
  parameter int unsigned WARMUP  = 16,
  parameter int unsigned HOLDOFF = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CW-1:0]       s_ch,
  input  logic [DW-1:0]       s_data,
  output logic                o_valid,
  output logic [CW-1:0]       o_ch,
  output logic                o_outlier,
  output logic [2*(DW+2)-1:0] o_dev2,
  output logic [N_CH-1:0]     status,
  input  logic [N_CH-1:0]     status_clr,
  output logic                irq
);

  stage_t               p1_q, p1_d, p2_q, p2_d;
  logic [D2W-1:0]       p2_d2_q, p2_d2_d;
  logic signed [MW-1:0] mean_q [N_CH];
  logic signed [MW-1:0] mean_d [N_CH];
  logic [D2W-1:0]       var_q  [N_CH];
  logic [D2W-1:0]       var_d  [N_CH];
  logic [CNTW-1:0]      cnt_q  [N_CH];
  logic [CNTW-1:0]      cnt_d  [N_CH];
  logic                 o_valid_q, o_valid_d, o_outlier_q, o_outlier_d;
  logic [CW-1:0]        o_ch_q, o_ch_d;
  logic [D2W-1:0]       o_dev2_q, o_dev2_d;

  logic                  accept_c;
  logic signed [MW-1:0]  samp_c;
  logic signed [D2W-1:0] sq_c;
  logic [TW-1:0]         thr_c;
  logic                  outlier_c;
  logic signed [MW-1:0]  mean_new_c;
  logic signed [D2W:0]   vdiff_c, vsum_c;
  logic [D2W-1:0]        var_new_c;
  logic [CNTW-1:0]       cnt_new_c;

  // No forwarding: a channel stalls while its previous sample sits in P1 or P2.
  always_comb begin
    s_ready  = !(p1_q.v && (p1_q.ch == s_ch)) && !(p2_q.v && (p2_q.ch == s_ch));
    accept_c = s_valid && s_ready;
  end

  // Accept: read channel state, compute deviation; the first sample seeds the mean.
  always_comb begin
    samp_c    = $signed(MW'(s_data));
    p1_d      = '0;
    p1_d.v    = accept_c;
    p1_d.ch   = s_ch;
    p1_d.vr   = var_q[s_ch];
    p1_d.cnt  = cnt_q[s_ch];
    if (cnt_q[s_ch] == '0) begin
      p1_d.mean = samp_c;
      p1_d.d    = '0;
    end else begin
      p1_d.mean = mean_q[s_ch];
      p1_d.d    = samp_c - mean_q[s_ch];
    end
  end

  // P1: square the deviation.
  always_comb begin
    sq_c    = D2W'($signed(p1_q.d)) * D2W'($signed(p1_q.d));
    p2_d    = p1_q;
    p2_d2_d = $unsigned(sq_c);
  end

  // P2: threshold test against pre-update state, then EMA update.
  always_comb begin
    thr_c      = TW'(p2_q.vr) * TW'(K2);
    outlier_c  = p2_q.v && (p2_q.cnt >= CNTW'(WARMUP)) && (TW'(p2_d2_q) > thr_c);
    mean_new_c = $signed(p2_q.mean) + ($signed(p2_q.d) >>> MSHIFT);
    vdiff_c    = $signed({1'b0, p2_d2_q}) - $signed({1'b0, p2_q.vr});
    vsum_c     = $signed({1'b0, p2_q.vr}) + (vdiff_c >>> VSHIFT);
    var_new_c  = vsum_c[D2W] ? '0 : vsum_c[D2W-1:0];
    cnt_new_c  = (p2_q.cnt >= CNTW'(WARMUP)) ? CNTW'(WARMUP) : p2_q.cnt + CNTW'(1);
  end

  // Register-file write-back and result registers.
  always_comb begin
    mean_d = mean_q;
    var_d  = var_q;
    cnt_d  = cnt_q;
    if (p2_q.v) begin
      mean_d[p2_q.ch] = mean_new_c;
      var_d[p2_q.ch]  = var_new_c;
      cnt_d[p2_q.ch]  = cnt_new_c;
    end
    o_valid_d   = p2_q.v;
    o_outlier_d = outlier_c;
    o_ch_d      = o_ch_q;
    o_dev2_d    = o_dev2_q;
    if (p2_q.v) begin
      o_ch_d   = p2_q.ch;
      o_dev2_d = p2_d2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q        <= '0;
      p2_q        <= '0;
      p2_d2_q     <= '0;
      o_valid_q   <= 1'b0;
      o_outlier_q <= 1'b0;
      o_ch_q      <= '0;
      o_dev2_q    <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        mean_q[i] <= '0;
        var_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p2_d2_q     <= p2_d2_d;
      o_valid_q   <= o_valid_d;
      o_outlier_q <= o_outlier_d;
      o_ch_q      <= o_ch_d;
      o_dev2_q    <= o_dev2_d;
      mean_q      <= mean_d;
      var_q       <= var_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_ch      = o_ch_q;
  assign o_outlier = o_outlier_q;
  assign o_dev2    = o_dev2_q;

  // irq is computed from the P2 decision so it lines up with o_valid.
  outlier_irq_gen #(
    .N_CH    (N_CH),
    .HOLDOFF (HOLDOFF)
  ) u_irq (
    .clk         (clk),
    .rst_n       (rst_n),
    .evt_c       (outlier_c),
    .res_valid   (o_valid_q),
    .res_ch      (o_ch_q),
    .res_outlier (o_outlier_q),
    .status_clr  (status_clr),
    .status      (status),
    .irq         (irq)
  );

endmodule

// File: tb/tb_outlier_engine_tdm.sv
// Directed bench for outlier_engine_tdm with a scoreboard fed by a small integer model.
module tb_outlier_engine_tdm;

  localparam int WARMUP  = 4;
  localparam int HOLDOFF = 8;
  localparam int K2      = 9;
  localparam int MSHIFT  = 4;
  localparam int VSHIFT  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready;
  logic [1:0]  s_ch;
  logic [9:0]  s_data;
  logic        o_valid, o_outlier, irq;
  logic [1:0]  o_ch;
  logic [23:0] o_dev2;
  logic [3:0]  status, status_clr;

  outlier_engine_tdm #(
    .N_CH(4), .DW(10), .MSHIFT(MSHIFT), .VSHIFT(VSHIFT), .K2(K2),
    .WARMUP(WARMUP), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_ch(s_ch), .s_data(s_data), .o_valid(o_valid), .o_ch(o_ch),
    .o_outlier(o_outlier), .o_dev2(o_dev2), .status(status),
    .status_clr(status_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     ch;
    bit     outl;
    longint dev2;
    int     due;
  } exp_t;

  exp_t   q[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  int     irq_cnt = 0;
  int     outl_seen = 0;
  longint m_mean [4];
  longint m_var  [4];
  int     m_cnt  [4];
  int     hold_m = 0;
  logic [3:0] st_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mean[i] = 0;
      m_var[i]  = 0;
      m_cnt[i]  = 0;
    end
  endtask

  // Reference model step, called at the negedge before the accepting edge.
  task automatic push_exp(input int ch, input int data);
    longint d, d2, thr, v;
    exp_t   e;
    if (m_cnt[ch] == 0) begin
      m_mean[ch] = data;
      d = 0;
    end else begin
      d = longint'(data) - m_mean[ch];
    end
    d2  = d * d;
    thr = m_var[ch] * K2;
    e.outl = (m_cnt[ch] >= WARMUP) && (d2 > thr);
    m_mean[ch] = m_mean[ch] + (d >>> MSHIFT);
    v = m_var[ch] + ((d2 - m_var[ch]) >>> VSHIFT);
    m_var[ch] = (v < 0) ? 0 : v;
    if (m_cnt[ch] < WARMUP) m_cnt[ch]++;
    e.ch   = ch;
    e.dev2 = d2;
    e.due  = cyc + 3;
    q.push_back(e);
  endtask

  task automatic send(input int ch, input int data);
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_ch    = 2'(ch);
    s_data  = 10'(data);
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (s_ready) begin
        push_exp(ch, data);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("send_accepted", {63'b0, done}, 64'd1);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle(6);
    check("scoreboard_empty", 64'(q.size()), 64'd0);
  endtask

  // Output monitor: scoreboard pop, latency, irq and status models.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   evt;
    logic [3:0] set_m;
    evt   = 1'b0;
    set_m = '0;
    if (!rst_n) begin
      hold_m = 0;
      st_m   = '0;
      check("rst_o_valid", {63'b0, o_valid}, 64'd0);
      check("rst_irq", {63'b0, irq}, 64'd0);
      check("rst_status", {60'b0, status}, 64'd0);
      check("rst_o_dev2", {40'b0, o_dev2}, 64'd0);
    end else begin
      if (o_valid) begin
        if (q.size() == 0) begin
          check("o_valid_unexpected", {63'b0, o_valid}, 64'd0);
        end else begin
          e = q.pop_front();
          check("o_latency", 64'(cyc), 64'(e.due));
          check("o_ch", {62'b0, o_ch}, 64'(e.ch));
          check("o_outlier", {63'b0, o_outlier}, {63'b0, e.outl});
          check("o_dev2", {40'b0, o_dev2}, 64'(e.dev2));
          evt = e.outl;
          if (e.outl) set_m[e.ch] = 1'b1;
        end
        if (o_outlier) outl_seen++;
      end else if (q.size() != 0 && q[0].due < cyc) begin
        check("o_valid_late", {63'b0, o_valid}, 64'd1);
        void'(q.pop_front());
      end
      check("irq", {63'b0, irq}, {63'b0, (evt && hold_m == 0)});
      check("status", {60'b0, status}, {60'b0, st_m});
      if (irq) irq_cnt++;
      hold_m = evt ? HOLDOFF : ((hold_m > 0) ? hold_m - 1 : 0);
      st_m   = (st_m & ~status_clr) | set_m;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   exp_rdy [4];
    int   base;
    exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; s_valid = 1'b0; s_ch = '0; s_data = '0; status_clr = '0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_s_ready", {63'b0, s_ready}, 64'd1);
    check("reset_o_valid", {63'b0, o_valid}, 64'd0);
    check("reset_irq", {63'b0, irq}, 64'd0);
    @(posedge clk); #1;

    // Warm-up on ch1: nothing flagged, counter saturates at WARMUP.
    send(1, 0); send(1, 900); send(1, 0); send(1, 900);
    drain();
    check("warmup_outliers", 64'(outl_seen), 64'd0);
    check("ch1_cnt", 64'(dut.cnt_q[1]), 64'd4);

    // Detection on ch0, with a clear pulse coinciding with the outlier result.
    repeat (5) send(0, 100);
    send(0, 300);
    @(posedge clk); #1;
    @(posedge clk); #1;
    status_clr = 4'b0001;
    @(posedge clk); #1;
    status_clr = 4'b0000;
    drain();
    check("detect_outliers", 64'(outl_seen), 64'd1);
    check("ch0_mean", 64'(dut.mean_q[0]), 64'd112);
    check("ch0_var", 64'(dut.var_q[0]), 64'd2500);
    check("status0_set_wins", {63'b0, status[0]}, 64'd1);
    status_clr = 4'b0001;
    @(posedge clk); #1;
    status_clr = 4'b0000;
    check("status0_cleared", {63'b0, status[0]}, 64'd0);

    // Same-channel hazard on ch2 with s_valid held.
    s_valid = 1'b1; s_ch = 2'd2; s_data = 10'd50;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hazard_ready", {63'b0, s_ready}, {63'b0, exp_rdy[i]});
      if (s_ready) push_exp(2, int'(s_data));
      @(posedge clk); #1;
      if (i == 0) s_data = 10'd60;
    end
    s_valid = 1'b0;
    drain();

    // Round-robin channels: never stalls.
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_ch   = 2'(i % 4);
      s_data = 10'((i * 131 + 40) % 1024);
      @(negedge clk);
      check("interleave_ready", {63'b0, s_ready}, 64'd1);
      if (s_ready) push_exp(i % 4, int'(s_data));
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    drain();

    // Reset with P1 (ch1) and P2 (ch0) occupied.
    send(0, 700);
    send(1, 800);
    rst_n = 1'b0;
    q.delete();
    model_reset();
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_mean", 64'(dut.mean_q[i]), 64'd0);
      check("rst_cnt", 64'(dut.cnt_q[i]), 64'd0);
    end
    rst_n = 1'b1;
    idle(6);
    send(0, 500);
    drain();
    check("reseed_mean", 64'(dut.mean_q[0]), 64'd500);

    // irq holdoff: outliers at results r, r+4 (suppressed), r+20.
    for (int i = 0; i < 4; i++) begin
      send(3, 200);
      send(2, 200);
    end
    drain();
    base = irq_cnt;
    send(3, 1000);
    idle(3);
    send(2, 1000);
    idle(15);
    check("irq_count_first", 64'(irq_cnt - base), 64'd1);
    send(3, 1023);
    drain();
    check("irq_count_second", 64'(irq_cnt - base), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
